// File: rtl/sieve_prime_reader.sv
// Scans the boolean sieve RAM from 2..max_prime and streams each unmarked index as a prime.
// Latency: 2 cycles per composite entry, 3+ per prime; stalls in EMIT until prime_ready.
// Backpressure holds prime_value stable; SIEVE_CLEAR_ON_READ_EN clears each entry as it is read.
module sieve_prime_reader #(
  parameter int ADDR_W  = 10,
  parameter int COUNT_W = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start_read,
  input  logic [ADDR_W-1:0]  max_prime,
  output logic [ADDR_W-1:0]  ram_rd_index,
  input  logic               ram_rd_data,
  output logic               ram_clr_wren,
  output logic               prime_valid,
  input  logic               prime_ready,
  output logic [ADDR_W-1:0]  prime_value,
  output logic [COUNT_W-1:0] prime_count,
  output logic               busy,
  output logic               done_reading
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_CHECK,
    S_EMIT,
    S_FINISH
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0]  index_q, index_d;
  logic [ADDR_W-1:0]  bound_q, bound_d;
  logic [ADDR_W-1:0]  rd_index_d;
  logic [ADDR_W-1:0]  value_d;
  logic [COUNT_W-1:0] count_d;
  logic               handshake;

  assign handshake    = (state_q == S_EMIT) && prime_ready;
  assign prime_valid  = (state_q == S_EMIT);
  assign busy         = (state_q != S_IDLE);
  assign done_reading = (state_q == S_FINISH);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      index_q      <= '0;
      bound_q      <= '0;
      ram_rd_index <= '0;
      prime_value  <= '0;
      prime_count  <= '0;
    end else begin
      state_q      <= state_d;
      index_q      <= index_d;
      bound_q      <= bound_d;
      ram_rd_index <= rd_index_d;
      prime_value  <= value_d;
      prime_count  <= count_d;
    end
  end

  // The RAM address is registered and loaded on entry to FETCH, so the read
  // issued during FETCH returns its data in CHECK.
  always_comb begin
    state_d    = state_q;
    index_d    = index_q;
    bound_d    = bound_q;
    rd_index_d = ram_rd_index;
    value_d    = prime_value;
    count_d    = prime_count;
    case (state_q)
      S_IDLE: begin
        rd_index_d = '0;
        if (start_read) begin
          bound_d = max_prime;
          index_d = ADDR_W'(2);
          count_d = '0;
          if (max_prime < ADDR_W'(2)) begin
            state_d = S_FINISH;
          end else begin
            state_d    = S_FETCH;
            rd_index_d = ADDR_W'(2);
          end
        end
      end
      S_FETCH: begin
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (!ram_rd_data) begin
          state_d = S_EMIT;
          value_d = index_q;
        end else if (index_q == bound_q) begin
          state_d = S_FINISH;
        end else begin
          state_d    = S_FETCH;
          index_d    = index_q + ADDR_W'(1);
          rd_index_d = index_q + ADDR_W'(1);
        end
      end
      S_EMIT: begin
        if (handshake) begin
          if (!(&prime_count)) count_d = prime_count + COUNT_W'(1);
          // Equality before increment keeps the index from wrapping at the top of the range.
          if (index_q == bound_q) begin
            state_d = S_FINISH;
          end else begin
            state_d    = S_FETCH;
            index_d    = index_q + ADDR_W'(1);
            rd_index_d = index_q + ADDR_W'(1);
          end
        end
      end
      S_FINISH: begin
        state_d    = S_IDLE;
        rd_index_d = '0;
      end
      default: begin
        state_d    = S_IDLE;
        rd_index_d = '0;
      end
    endcase
  end

`ifdef SIEVE_CLEAR_ON_READ_EN
  assign ram_clr_wren = ((state_q == S_CHECK) && ram_rd_data) || handshake;
`else
  assign ram_clr_wren = 1'b0;
`endif

endmodule

// File: tb/tb_sieve_prime_reader.sv
// Directed bench for sieve_prime_reader: small image, backpressure, empty range, full sieve, saturation, reset.
module tb_sieve_prime_reader;

  logic       clock = 1'b0;
  logic       reset;
  logic       start_read;
  logic [9:0] max_prime;
  logic [9:0] ram_rd_index;
  logic       ram_rd_data;
  logic       ram_clr_wren;
  logic       prime_valid;
  logic       prime_ready;
  logic [9:0] prime_value;
  logic [7:0] prime_count;
  logic       busy;
  logic       done_reading;

  always #5 clock = ~clock;

  sieve_prime_reader #(.ADDR_W(10), .COUNT_W(8)) dut (
    .clock        (clock),
    .reset        (reset),
    .start_read   (start_read),
    .max_prime    (max_prime),
    .ram_rd_index (ram_rd_index),
    .ram_rd_data  (ram_rd_data),
    .ram_clr_wren (ram_clr_wren),
    .prime_valid  (prime_valid),
    .prime_ready  (prime_ready),
    .prime_value  (prime_value),
    .prime_count  (prime_count),
    .busy         (busy),
    .done_reading (done_reading)
  );

  // RAM model: img is the sieve image, cleared tracks entries written back to 0.
  logic [1023:0] img;
  logic [1023:0] cleared;
  logic          clr_flush;
  int            clr_total;

  always @(posedge clock) begin
    ram_rd_data <= img[ram_rd_index] & ~cleared[ram_rd_index];
    if (clr_flush) cleared <= '0;
    else if (ram_clr_wren) cleared[ram_rd_index] <= 1'b1;
  end

  initial clr_total = 0;
  always @(negedge clock) if (!reset && ram_clr_wren) clr_total++;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  int exp_q[$];
  int got_q[$];
  int done_at, done_cnt, hold_cnt, clr_cnt;

  // mode 0: small image, 1: true sieve of 0..1023, 2: all zero
  task automatic load_img(input int mode);
    img = '0;
    exp_q.delete();
    if (mode == 0) begin
      img[4] = 1'b1; img[6] = 1'b1; img[8] = 1'b1; img[9] = 1'b1; img[10] = 1'b1;
    end else if (mode == 1) begin
      for (int i = 2; i < 1024; i++)
        if (!img[i]) begin
          exp_q.push_back(i);
          for (int j = i * i; j < 1024; j += i) img[j] = 1'b1;
        end
    end
    clr_flush = 1'b1;
    @(posedge clock); #1;
    clr_flush = 1'b0;
  endtask

  // Called and returns 1 time unit after a rising edge.
  task automatic run_scan(input logic [9:0] bound, input int stall_val, input int stall_len, input bit poke);
    int stall;
    int clr0;
    stall    = 0;
    got_q.delete();
    done_at  = -1;
    done_cnt = 0;
    hold_cnt = 0;
    clr0     = clr_total;
    start_read  = 1'b1;
    max_prime   = bound;
    prime_ready = 1'b1;
    @(posedge clock); #1;
    start_read = 1'b0;
    for (int c = 0; c < 6000 && done_at < 0; c++) begin
      if (done_reading) begin
        done_cnt++;
        done_at = c;
      end
      prime_ready = 1'b1;
      if (prime_valid) begin
        if (int'(prime_value) == stall_val) hold_cnt++;
        if (int'(prime_value) == stall_val && stall < stall_len) begin
          prime_ready = 1'b0;
          stall++;
        end else begin
          got_q.push_back(int'(prime_value));
        end
      end
      start_read = poke && (c == 3);
      if (poke && c == 3) max_prime = 10'd1023;
      @(posedge clock); #1;
    end
    start_read  = 1'b0;
    prime_ready = 1'b0;
    if (done_at < 0) chk("scan_timeout", 32'd0, 32'd1);
    chk("done_one_cycle", {31'd0, done_reading}, 32'd0);
    chk("busy_after", {31'd0, busy}, 32'd0);
    clr_cnt = clr_total - clr0;
  endtask

  task automatic chk_small(input string tag);
    int exp_small[4];
    exp_small = '{2, 3, 5, 7};
    chk({tag, "_n"}, got_q.size(), 32'd4);
    for (int i = 0; i < 4 && i < got_q.size(); i++)
      chk({tag, "_prime"}, got_q[i], exp_small[i]);
    chk({tag, "_count"}, {24'd0, prime_count}, 32'd4);
    chk({tag, "_done"}, done_cnt, 32'd1);
  endtask

  initial begin
    int nmis;
    int n3;
    reset       = 1'b1;
    start_read  = 1'b0;
    max_prime   = '0;
    prime_ready = 1'b0;
    clr_flush   = 1'b0;
    img         = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_valid", {31'd0, prime_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done_reading}, 32'd0);
    chk("rst_index", {22'd0, ram_rd_index}, 32'd0);
    chk("rst_count", {24'd0, prime_count}, 32'd0);
    chk("rst_value", {22'd0, prime_value}, 32'd0);
    reset = 1'b0;

    // Small scan
    load_img(0);
    run_scan(10'd10, -1, 0, 1'b0);
    chk_small("small");
`ifdef SIEVE_CLEAR_ON_READ_EN
    chk("clr_pulses", clr_cnt, 32'd9);
    nmis = 0;
    for (int i = 2; i <= 10; i++) if (img[i] & ~cleared[i]) nmis++;
    chk("clr_ram_zero", nmis, 32'd0);
`else
    chk("clr_pulses", clr_cnt, 32'd0);
`endif

    // Backpressure on prime 3, plus a start_read poke mid-scan that must be ignored
    load_img(0);
    run_scan(10'd10, 3, 5, 1'b1);
    chk_small("bp");
    chk("bp_hold_cycles", hold_cnt, 32'd6);
    n3 = 0;
    foreach (got_q[i]) if (got_q[i] == 3) n3++;
    chk("bp_three_once", n3, 32'd1);

    // Empty range
    load_img(0);
    run_scan(10'd1, -1, 0, 1'b0);
    chk("empty_n", got_q.size(), 32'd0);
    chk("empty_done_at", done_at, 32'd0);
    chk("empty_count", {24'd0, prime_count}, 32'd0);

    // Full sieve image up to the top of the index range
    load_img(1);
    run_scan(10'd1023, -1, 0, 1'b0);
    chk("full_n", got_q.size(), 32'd172);
    if (got_q.size() > 0) chk("full_last", got_q[got_q.size()-1], 32'd1021);
    else chk("full_last", 32'd0, 32'd1021);
    chk("full_count", {24'd0, prime_count}, 32'd172);
    nmis = 0;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) if (got_q[i] != exp_q[i]) nmis++;
    chk("full_seq", nmis, 32'd0);
    chk("full_done", done_cnt, 32'd1);

    // All-zero image: 1022 emissions, count saturates
    load_img(2);
    run_scan(10'd1023, -1, 0, 1'b0);
    chk("sat_n", got_q.size(), 32'd1022);
    chk("sat_count", {24'd0, prime_count}, 32'd255);

    // Reset while prime 5 is pending, then restart
    load_img(0);
    start_read  = 1'b1;
    max_prime   = 10'd10;
    prime_ready = 1'b1;
    @(posedge clock); #1;
    start_read = 1'b0;
    n3 = 0;
    for (int c = 0; c < 100; c++) begin
      if (prime_valid && prime_value == 10'd5) begin
        n3 = 1;
        break;
      end
      @(posedge clock); #1;
    end
    chk("rr_saw5", n3, 32'd1);
    prime_ready = 1'b0;
    reset       = 1'b1;
    @(posedge clock); #1;
    chk("rr_valid", {31'd0, prime_valid}, 32'd0);
    chk("rr_busy", {31'd0, busy}, 32'd0);
    chk("rr_done", {31'd0, done_reading}, 32'd0);
    chk("rr_index", {22'd0, ram_rd_index}, 32'd0);
    chk("rr_value", {22'd0, prime_value}, 32'd0);
    chk("rr_count", {24'd0, prime_count}, 32'd0);
    chk("rr_clr", {31'd0, ram_clr_wren}, 32'd0);
    reset = 1'b0;
    load_img(0);
    run_scan(10'd10, -1, 0, 1'b0);
    chk_small("restart");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
